// File: rtl/sum16_seq_ctrl.sv
// Multi-cycle W-bit add/subtract unit built around one shared 4-bit ripple adder.
// Operand nibbles are fed LSB-first, one per cycle, with the carry chained through
// a register; the result and flags are published only when the last nibble lands.

// 4-bit ripple-carry adder, the single arithmetic resource that gets time-shared.
module sum4_v1 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_ci,
    output logic [3:0] o_s,
    output logic       o_co
);
    logic [4:0] w_c;

    assign w_c[0] = i_ci;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bit
            assign o_s[gi]     = i_a[gi] ^ i_b[gi] ^ w_c[gi];
            assign w_c[gi + 1] = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
        end
    endgenerate

    assign o_co = w_c[4];
endmodule

module sum16_seq_ctrl #(
    parameter int NIB = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               op,
    input  logic [4*NIB-1:0]   A,
    input  logic [4*NIB-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [4*NIB-1:0]   S,
    output logic               c_out,
    output logic               ovf,
    output logic               zero
);
    localparam int W      = 4 * NIB;
    localparam int STEP_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NIB - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                w_load;
    logic                w_step_en;
    logic                w_last;

    logic [W-1:0]        r_opa;
    logic [W-1:0]        r_opb;
    logic                r_carry;
    logic [STEP_W-1:0]   r_step;
    logic [W-1:0]        r_acc;
    logic [W-1:0]        r_s;
    logic                r_cout;
    logic                r_ovf;
    logic                r_zero;

    logic [3:0]          w_a_nib [NIB];
    logic [3:0]          w_b_nib [NIB];
    logic [3:0]          w_sum;
    logic                w_co;
    logic [W-1:0]        w_acc_next;
    logic                w_ovf_next;
    logic                w_zero_next;

    // Split the captured operands into nibbles so the active step can pick one,
    // and splice the adder output into the accumulator at the active step.
    generate
        for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
            assign w_a_nib[gi] = r_opa[4*gi +: 4];
            assign w_b_nib[gi] = r_opb[4*gi +: 4];
            assign w_acc_next[4*gi +: 4] =
                (r_step == STEP_W'(gi)) ? w_sum : r_acc[4*gi +: 4];
        end
    endgenerate

    sum4_v1 u_sum4 (
        .i_a  (w_a_nib[r_step]),
        .i_b  (w_b_nib[r_step]),
        .i_ci (r_carry),
        .o_s  (w_sum),
        .o_co (w_co)
    );

    // opB already holds ~B for subtraction, so this is the usual same-sign-in,
    // different-sign-out overflow rule for both operations.
    assign w_ovf_next  = (r_opa[W-1] == r_opb[W-1]) && (w_acc_next[W-1] != r_opa[W-1]);
    assign w_zero_next = (w_acc_next == '0);

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake decode; DONE accepts start like IDLE for back-to-back use.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step_en    = 1'b0;
        w_last       = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy      = 1'b1;
                w_step_en = 1'b1;
                if (r_step == LAST_STEP) begin
                    w_last       = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Operand capture, nibble stepping, and result publication on the last step.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_opa   <= '0;
            r_opb   <= '0;
            r_carry <= 1'b0;
            r_step  <= '0;
            r_acc   <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            if (w_load) begin
                r_opa   <= A;
                r_opb   <= op ? ~B : B;
                r_carry <= op;
                r_step  <= '0;
                r_acc   <= '0;
            end else if (w_step_en) begin
                r_acc   <= w_acc_next;
                r_carry <= w_co;
                r_step  <= w_last ? '0 : r_step + STEP_W'(1);
            end
            if (w_last) begin
                r_s    <= w_acc_next;
                r_cout <= w_co;
                r_ovf  <= w_ovf_next;
                r_zero <= w_zero_next;
            end
        end
    end

    assign S     = r_s;
    assign c_out = r_cout;
    assign ovf   = r_ovf;
    assign zero  = r_zero;
endmodule

// File: tb/tb_sum16_seq_ctrl.sv
// Bench for sum16_seq_ctrl: directed table, multi-cycle corner sequences, and
// random operations checked against a plain-arithmetic reference model.
module tb_sum16_seq_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        busy;
    logic        done;
    logic [15:0] S;
    logic        c_out;
    logic        ovf;
    logic        zero;

    int n_pass  = 0;
    int n_total = 0;

    sum16_seq_ctrl #(.NIB(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .S       (S),
        .c_out   (c_out),
        .ovf     (ovf),
        .zero    (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] s;
        logic        c;
        logic        v;
        logic        z;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Reference: integer arithmetic, carry = no unsigned overflow/borrow semantics,
    // overflow = true signed result outside 16-bit range.
    function automatic void model(input logic o, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] s, output logic c,
                                  output logic v, output logic z);
        int sa;
        int sb;
        int r;
        int ua;
        int ub;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = int'(a);
        ub = int'(b);
        if (!o) begin
            s = a + b;
            c = (ua + ub) > 65535;
            r = sa + sb;
        end else begin
            s = a - b;
            c = (ua >= ub);
            r = sa - sb;
        end
        v = (r > 32767) || (r < -32768);
        z = (s == 16'h0000);
    endfunction

    // Issue one operation from a ready state (IDLE or DONE, just after an edge)
    // and check handshake timing and results; returns in the done cycle.
    task automatic do_op(input string tag, input logic o, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] es, input logic ec, input logic ev, input logic ez);
        int lat;
        int busy_cnt;
        op = o; A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = 16'($urandom); B = 16'($urandom); op = 1'($urandom);
        busy_cnt = busy ? 1 : 0;
        lat = 0;
        while (!done && lat < 10) begin
            @(posedge clk); #1;
            lat++;
            if (!done && busy) busy_cnt++;
        end
        $display("%s: op=%0d A=%04h B=%04h -> S=%04h c=%0d v=%0d z=%0d lat=%0d",
                 tag, o, a, b, S, c_out, ovf, zero, lat);
        chk({tag, " latency"}, 32'(lat), 32'd4);
        chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'd4);
        chk({tag, " busy_in_done"}, 32'(busy), 32'd0);
        chk({tag, " S"}, 32'(S), 32'(es));
        chk({tag, " c_out"}, 32'(c_out), 32'(ec));
        chk({tag, " ovf"}, 32'(ovf), 32'(ev));
        chk({tag, " zero"}, 32'(zero), 32'(ez));
    endtask

    task automatic count_dones(input string tag, input int cycles);
        int n;
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (done) n++;
        end
        chk({tag, " extra_done"}, 32'(n), 32'd0);
    endtask

    initial begin
        logic [15:0] ms;
        logic        mc;
        logic        mv;
        logic        mz;
        int          gap;
        logic        ro;
        logic [15:0] ra;
        logic [15:0] rb;

        vecs[0] = '{1'b0, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0};

        // Reset state
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        chk("rst S", 32'(S), 0);
        chk("rst c_out", 32'(c_out), 0);
        chk("rst ovf", 32'(ovf), 0);
        chk("rst zero", 32'(zero), 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed table; vectors 4 and 5 run back-to-back (start in done cycle)
        for (int i = 0; i < 6; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].s, vecs[i].c, vecs[i].v, vecs[i].z);
            if (i != 4) begin
                @(posedge clk); #1;
                chk($sformatf("vec%0d done_pulse_width", i), 32'(done), 0);
                chk($sformatf("vec%0d S_hold", i), 32'(S), 32'(vecs[i].s));
            end
        end

        // Start while busy must be ignored
        op = 1'b0; A = 16'h1234; B = 16'h0FCD; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        op = 1'b0; A = 16'hAAAA; B = 16'h0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        begin
            int lat;
            lat = 0;
            while (!done && lat < 10) begin
                @(posedge clk); #1;
                lat++;
            end
            $display("busy_ignore: S=%04h lat_after_second_start=%0d", S, lat);
            chk("busy_ignore lat", 32'(lat), 32'd2);
            chk("busy_ignore S", 32'(S), 32'h2201);
        end
        count_dones("busy_ignore", 8);

        // Reset during the third RUN cycle
        op = 1'b0; A = 16'h1111; B = 16'h2222; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        $display("midop_reset: busy=%0d done=%0d S=%04h", busy, done, S);
        chk("midop_reset busy", 32'(busy), 0);
        chk("midop_reset done", 32'(done), 0);
        chk("midop_reset S", 32'(S), 0);
        chk("midop_reset c_out", 32'(c_out), 0);
        reset_n = 1'b1;
        count_dones("midop_reset", 8);
        do_op("after_reset", 1'b0, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, 1'b0);

        // Random operations against the reference model, with random idle gaps
        for (int i = 0; i < 40; i++) begin
            gap = int'($urandom_range(0, 2));
            repeat (gap) begin
                @(posedge clk); #1;
            end
            ro = 1'($urandom);
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 8 == 0) rb = ra;
            model(ro, ra, rb, ms, mc, mv, mz);
            do_op($sformatf("rand%0d", i), ro, ra, rb, ms, mc, mv, mz);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
